// File: rtl/cmd_ram_burst_pkg.sv
// cmd_ram_pkg: command codes and read-FSM states shared by the command RAM block.
package cmd_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_MEM  = 2'b01,
        RD_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/cmd_ram_burst_if.sv
// cmd_ram_burst_if: frame input from the SPI deserialiser and read response to the serialiser.
// par_err exists only when CMD_RAM_PARITY_EN is defined.
interface cmd_ram_burst_if #(
    parameter int DATA_W = 8
) ();

    logic              rx_valid;
    logic [DATA_W+1:0] din;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              busy;
    logic              err;
`ifdef CMD_RAM_PARITY_EN
    logic              par_err;
`endif

`ifdef CMD_RAM_PARITY_EN
    modport slave  (input rx_valid, din, output dout, tx_valid, busy, err, par_err);
    modport master (output rx_valid, din, input dout, tx_valid, busy, err, par_err);
`else
    modport slave  (input rx_valid, din, output dout, tx_valid, busy, err);
    modport master (output rx_valid, din, input dout, tx_valid, busy, err);
`endif

endinterface

// File: rtl/cmd_ram_burst_sp_ram.sv
// sp_ram: single-port RAM with synchronous (registered) read, written to map onto block RAM.
// Contents are deliberately not reset.
module sp_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];
    logic [DATA_W-1:0] rdata_r;

    // Single shared address: write when enabled, always register the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata_r <= mem_r[addr];
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/cmd_ram_burst.sv
// cmd_ram_burst: command-decoded RAM behind an SPI slave, with a registered read path
// (tx_valid pulse), optional auto-increment addressing and a sticky protocol-error flag.
// Optional feature macro: CMD_RAM_PARITY_EN adds a stored even-parity bit per word and
// a sticky par_err output raised together with tx_valid on a parity mismatch.
module cmd_ram_burst
    import cmd_ram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int AUTO_INC = 1
) (
    input  logic           clk,
    input  logic           rst,
    cmd_ram_burst_if.slave bus
);

    // The write address is taken from the payload, so it must fit in a word.
    generate
        if (ADDR_W > DATA_W) begin : g_width_chk
            $error("cmd_ram_burst: ADDR_W must not exceed DATA_W");
        end
    endgenerate

`ifdef CMD_RAM_PARITY_EN
    localparam int PAR_W = 1;

    function automatic logic parity_bit(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`else
    localparam int PAR_W = 0;
`endif
    localparam int RAM_W = DATA_W + PAR_W;

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [ADDR_W-1:0]   rd_addr_r;
    logic                rd_addr_set_r;
    logic [DATA_W-1:0]   dout_r;
    logic                tx_valid_r;
    logic                busy_r;
    logic                err_r;
    logic                accept_s;
    logic [1:0]          cmd_s;
    logic [DATA_W-1:0]   payload_s;
    logic                ram_we_s;
    logic [ADDR_W-1:0]   ram_addr_s;
    logic [RAM_W-1:0]    ram_wdata_s;
    logic [RAM_W-1:0]    ram_rdata_s;
`ifdef CMD_RAM_PARITY_EN
    logic                par_err_r;
`endif

    assign cmd_s     = bus.din[DATA_W+1:DATA_W];
    assign payload_s = bus.din[DATA_W-1:0];

    // Frame decode, RAM port steering and next-state selection.
    always_comb begin
        accept_s     = 1'b0;
        ram_we_s     = 1'b0;
        ram_addr_s   = rd_addr_r;
        state_next_s = state_r;
        if (bus.rx_valid && (state_r == IDLE) && !busy_r) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        // Writes only happen in IDLE and reads only in RD_MEM, so the one port never conflicts.
        if (state_r == IDLE) begin
            ram_addr_s = wr_addr_r;
            ram_we_s   = accept_s && (cmd_s == CMD_WR_DATA);
        end else begin
            ram_addr_s = rd_addr_r;
            ram_we_s   = 1'b0;
        end
        case (state_r)
            IDLE: begin
                if (accept_s && (cmd_s == CMD_RD_DATA)) begin
                    state_next_s = RD_MEM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD_MEM:  state_next_s = RD_RESP;
            RD_RESP: state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

`ifdef CMD_RAM_PARITY_EN
    assign ram_wdata_s = {parity_bit(payload_s), payload_s};
`else
    assign ram_wdata_s = payload_s;
`endif

    sp_ram #(
        .DATA_W (RAM_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    // State register, address counters, registered outputs and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            wr_addr_r     <= {ADDR_W{1'b0}};
            rd_addr_r     <= {ADDR_W{1'b0}};
            rd_addr_set_r <= 1'b0;
            dout_r        <= {DATA_W{1'b0}};
            tx_valid_r    <= 1'b0;
            busy_r        <= 1'b0;
            err_r         <= 1'b0;
`ifdef CMD_RAM_PARITY_EN
            par_err_r     <= 1'b0;
`endif
        end else begin
            state_r    <= state_next_s;
            busy_r     <= (state_next_s != IDLE);
            tx_valid_r <= (state_r == RD_RESP);
            // A frame arriving during a read is dropped and flagged.
            if (bus.rx_valid && busy_r) begin
                err_r <= 1'b1;
            end
            if (accept_s) begin
                case (cmd_s)
                    CMD_WR_ADDR: wr_addr_r <= payload_s[ADDR_W-1:0];
                    CMD_WR_DATA: begin
                        if (AUTO_INC != 0) begin
                            wr_addr_r <= wr_addr_r + ADDR_W'(1);
                        end
                    end
                    CMD_RD_ADDR: begin
                        rd_addr_r     <= payload_s[ADDR_W-1:0];
                        rd_addr_set_r <= 1'b1;
                    end
                    CMD_RD_DATA: begin
                        // Reading before any RD_ADDR is allowed (from address 0) but flagged.
                        if (!rd_addr_set_r) begin
                            err_r <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (state_r == RD_RESP) begin
                dout_r <= ram_rdata_s[DATA_W-1:0];
                if (AUTO_INC != 0) begin
                    rd_addr_r <= rd_addr_r + ADDR_W'(1);
                end
`ifdef CMD_RAM_PARITY_EN
                if (ram_rdata_s[DATA_W] != parity_bit(ram_rdata_s[DATA_W-1:0])) begin
                    par_err_r <= 1'b1;
                end
`endif
            end
        end
    end

    assign bus.dout     = dout_r;
    assign bus.tx_valid = tx_valid_r;
    assign bus.busy     = busy_r;
    assign bus.err      = err_r;
`ifdef CMD_RAM_PARITY_EN
    assign bus.par_err  = par_err_r;
`endif

endmodule

// File: tb/tb_cmd_ram_burst.sv
// tb_cmd_ram_burst: directed and randomized frames checked against an array-based model
// of the command RAM (memory contents, addresses, sticky error).
module tb_cmd_ram_burst;

    localparam int DW = 8;
    localparam int AW = 8;

    logic clk;
    logic rst;

    cmd_ram_burst_if #(.DATA_W(DW)) bus ();

    cmd_ram_burst #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .AUTO_INC (1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] m_mem   [256];
    bit            m_known [256];
    logic [AW-1:0] m_wr;
    logic [AW-1:0] m_rd;
    bit            m_rd_set;
    bit            m_err;
    bit            m_par;

    task automatic model_reset();
        m_wr = 8'h00; m_rd = 8'h00; m_rd_set = 1'b0; m_err = 1'b0; m_par = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; bus.rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Drive one frame for one cycle; rx_valid stays high until the next drive or idle.
    task automatic send_frame(input logic [1:0] cmd, input logic [7:0] pl);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.din = {cmd, pl};
        case (cmd)
            2'b00: m_wr = pl;
            2'b01: begin m_mem[m_wr] = pl; m_known[m_wr] = 1'b1; m_wr = m_wr + 8'd1; end
            2'b10: begin m_rd = pl; m_rd_set = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic idle();
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    // Issue RD_DATA, optionally intrude a frame while busy, and check the full response timing.
    task automatic do_read(input bit intrude, input logic [9:0] ifr, output logic [7:0] got);
        logic [7:0] exp;
        bit known;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.din = {2'b11, 8'(($urandom_range(0, 255)))};
        if (!m_rd_set) m_err = 1'b1;
        exp = m_mem[m_rd];
        known = m_known[m_rd];
        m_rd = m_rd + 8'd1;
        @(negedge clk);
        if (intrude) begin
            bus.rx_valid = 1'b1; bus.din = ifr; m_err = 1'b1;
        end else begin
            bus.rx_valid = 1'b0;
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_cycle1 busy=%b tx_valid=%b required busy=1 tx_valid=0", bus.busy, bus.tx_valid);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_cycle2 busy=%b tx_valid=%b required busy=1 tx_valid=0", bus.busy, bus.tx_valid);
        end
        @(negedge clk);
        got = bus.dout;
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_resp tx_valid=%b busy=%b required tx_valid=1 busy=0", bus.tx_valid, bus.busy);
        end
        if (known) begin
            checks++;
            if (bus.dout !== exp) begin
                errors++;
                $display("FAIL rd_data dout=%h required %h", bus.dout, exp);
            end
        end
`ifdef CMD_RAM_PARITY_EN
        checks++;
        if (bus.par_err !== m_par) begin
            errors++;
            $display("FAIL par_err par_err=%b required %b", bus.par_err, m_par);
        end
`endif
        @(negedge clk);
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.dout !== got || bus.err !== m_err) begin
            errors++;
            $display("FAIL rd_after tx_valid=%b dout=%h err=%b required tx_valid=0 dout=%h err=%b",
                     bus.tx_valid, bus.dout, bus.err, got, m_err);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.dout !== 8'h00) begin
            errors++;
            $display("FAIL reset tx_valid=%b busy=%b err=%b dout=%h required 0 0 0 00",
                     bus.tx_valid, bus.busy, bus.err, bus.dout);
        end
    endtask

    task automatic test_read_no_addr();
        logic [7:0] got;
        send_frame(2'b01, 8'h5A);      // wr_addr is 0 after reset
        do_read(1'b0, 10'h000, got);
        checks++;
        if (got !== 8'h5A || bus.err !== 1'b1) begin
            errors++;
            $display("FAIL read_no_addr dout=%h err=%b required 5a 1", got, bus.err);
        end
        apply_reset();
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear err=%b required 0", bus.err);
        end
    endtask

    task automatic test_basic();
        logic [7:0] got;
        send_frame(2'b00, 8'h10);
        send_frame(2'b01, 8'hA5);
        send_frame(2'b10, 8'h10);
        do_read(1'b0, 10'h000, got);
        checks++;
        if (got !== 8'hA5 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL basic dout=%h err=%b required a5 0", got, bus.err);
        end
    endtask

    task automatic test_burst();
        logic [7:0] got;
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33;
        send_frame(2'b00, 8'hFE);
        send_frame(2'b01, 8'h11);
        send_frame(2'b01, 8'h22);
        send_frame(2'b01, 8'h33);
        send_frame(2'b10, 8'hFE);
        for (int i = 0; i < 3; i++) begin
            do_read(1'b0, 10'h000, got);
            checks++;
            if (got !== exp_seq[i]) begin
                errors++;
                $display("FAIL burst_%0d dout=%h required %h", i, got, exp_seq[i]);
            end
        end
        // Read-after-write on consecutive frames (rd_addr has wrapped to 0x01)
        send_frame(2'b00, 8'h01);
        send_frame(2'b01, 8'h99);
        do_read(1'b0, 10'h000, got);
        checks++;
        if (got !== 8'h99 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL raw dout=%h err=%b required 99 0", got, bus.err);
        end
    endtask

    task automatic test_busy_drop();
        logic [7:0] got;
        send_frame(2'b00, 8'h10);      // wr_addr -> 0x10 (holds 0xA5)
        send_frame(2'b10, 8'h10);
        do_read(1'b1, {2'b01, 8'h77}, got);
        checks++;
        if (got !== 8'hA5 || bus.err !== 1'b1) begin
            errors++;
            $display("FAIL busy_drop dout=%h err=%b required a5 1", got, bus.err);
        end
        send_frame(2'b10, 8'h10);
        do_read(1'b0, 10'h000, got);
        checks++;
        if (got !== 8'hA5) begin
            errors++;
            $display("FAIL busy_drop_mem dout=%h required a5", got);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] got;
        send_frame(2'b10, 8'h20);
        send_frame(2'b11, 8'h00);      // accepted at the next edge
        @(negedge clk);                 // now in RD_MEM
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_%0d tx_valid=%b busy=%b err=%b required 0 0 0",
                         i, bus.tx_valid, bus.busy, bus.err);
            end
            @(negedge clk);
        end
        send_frame(2'b01, 8'h3E);      // lands at wr_addr 0
        do_read(1'b0, 10'h000, got);    // from rd_addr 0, flagged
        checks++;
        if (got !== 8'h3E || bus.err !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_addr dout=%h err=%b required 3e 1", got, bus.err);
        end
    endtask

`ifdef CMD_RAM_PARITY_EN
    task automatic test_parity();
        logic [7:0] got;
        send_frame(2'b00, 8'h40);
        send_frame(2'b01, 8'h3C);
        send_frame(2'b10, 8'h40);
        do_read(1'b0, 10'h000, got);
        idle();
        u_dut.u_ram.mem_r[64][8] = ~u_dut.u_ram.mem_r[64][8];
        send_frame(2'b10, 8'h40);
        m_par = 1'b1;
        do_read(1'b0, 10'h000, got);
        checks++;
        if (got !== 8'h3C) begin
            errors++;
            $display("FAIL parity_data dout=%h required 3c", got);
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0] got;
        logic [1:0] c;
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            c = 2'($urandom_range(0, 3));
            if (c == 2'b11) begin
                do_read(($urandom_range(0, 7) == 0), 10'($urandom_range(0, 1023)), got);
            end else begin
                // Keep addresses in a small window so reads often hit written words.
                send_frame(c, 8'($urandom_range(0, 15)) + ((c == 2'b01) ? 8'($urandom_range(0, 255)) : 8'h00));
            end
        end
        idle();
    endtask

    initial begin
        rst = 1'b0;
        bus.rx_valid = 1'b0;
        bus.din = 10'h000;
        for (int i = 0; i < 256; i++) begin
            m_mem[i] = 8'h00;
            m_known[i] = 1'b0;
        end
        model_reset();
        test_reset();
        test_read_no_addr();
        test_basic();
        test_burst();
        test_busy_drop();
        test_reset_mid_read();
`ifdef CMD_RAM_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
